// File: rtl/replacement_policy_ctrl.sv
// rtl/replacement_policy_ctrl.sv - per-set cache way-replacement controller (LRU / PLRU / random)
module replacement_policy_ctrl #(
    parameter int          N_WAYS     = 4,
    parameter int          LINE_OFF_W = 2,
    parameter int          NWAY_W     = $clog2(N_WAYS),
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            policy_sel,
    input  logic                  flush_req,
    output logic                  busy,
    input  logic                  look_valid,
    output logic                  look_ready,
    input  logic [LINE_OFF_W-1:0] look_addr,
    input  logic [N_WAYS-1:0]     way_valid,
    output logic                  sel_valid,
    output logic [N_WAYS-1:0]     way_select,
    output logic [NWAY_W-1:0]     way_select_bin,
    input  logic                  upd_en,
    input  logic [LINE_OFF_W-1:0] upd_addr,
    input  logic [N_WAYS-1:0]     upd_way_hit
);

    localparam int DEPTH = 2 ** LINE_OFF_W;
    localparam int SW    = N_WAYS * NWAY_W;

    localparam logic [1:0] POL_LRU  = 2'd0;
    localparam logic [1:0] POL_MRU  = 2'd1;
    localparam logic [1:0] POL_RAND = 2'd2;
    localparam logic [1:0] POL_TREE = 2'd3;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t                  state;
    logic [LINE_OFF_W-1:0]   cnt;
    logic [1:0]              policy;
    logic [15:0]             lfsr;
    logic [SW-1:0]           mem [DEPTH];

    logic                    look_fire;
    logic                    flush_take;
    logic                    upd_fire;
    logic [SW-1:0]           upd_next;
    logic [SW-1:0]           look_state;
    logic [NWAY_W-1:0]       victim;

    function automatic logic [NWAY_W-1:0] onehot_idx(input logic [N_WAYS-1:0] oh);
        logic [NWAY_W-1:0] idx;
        idx = '0;
        for (int i = N_WAYS - 1; i >= 0; i--)
            if (oh[i]) idx = NWAY_W'(i);
        return idx;
    endfunction

    function automatic logic [SW-1:0] init_state(input logic [1:0] pol);
        logic [SW-1:0] s;
        s = '0;
        if (pol == POL_LRU)
            for (int i = 0; i < N_WAYS; i++) s[i*NWAY_W +: NWAY_W] = NWAY_W'(i);
        return s;
    endfunction

    function automatic logic [SW-1:0] update_state(input logic [SW-1:0] st,
                                                   input logic [N_WAYS-1:0] hit,
                                                   input logic [1:0] pol);
        logic [SW-1:0]     ns;
        logic [NWAY_W-1:0] w, old, f;
        logic [N_WAYS-1:0] mru;
        logic              b;
        int                n;
        ns  = st;
        w   = onehot_idx(hit);
        n   = 0;
        case (pol)
            POL_LRU: begin
                old = st[int'(w)*NWAY_W +: NWAY_W];
                for (int i = 0; i < N_WAYS; i++) begin
                    f = st[i*NWAY_W +: NWAY_W];
                    if (i == int'(w)) ns[i*NWAY_W +: NWAY_W] = NWAY_W'(N_WAYS - 1);
                    else if (f > old) ns[i*NWAY_W +: NWAY_W] = f - 1'b1;
                end
            end
            POL_MRU: begin
                mru = st[N_WAYS-1:0];
                if (&(mru | hit)) mru = hit;
                else              mru = mru | hit;
                ns = '0;
                ns[N_WAYS-1:0] = mru;
            end
            POL_TREE: begin
                // Heap-ordered nodes: children of node n are 2n+1 (left) and 2n+2 (right).
                for (int lvl = 0; lvl < NWAY_W; lvl++) begin
                    b     = w[NWAY_W-1-lvl];
                    ns[n] = ~b;
                    n     = 2 * n + (b ? 2 : 1);
                end
            end
            default: ns = st;
        endcase
        return ns;
    endfunction

    function automatic logic [NWAY_W-1:0] pick_victim(input logic [SW-1:0] st,
                                                      input logic [N_WAYS-1:0] valid,
                                                      input logic [1:0] pol,
                                                      input logic [15:0] rnd);
        logic [NWAY_W-1:0] v;
        logic              b;
        int                n;
        v = '0;
        n = 0;
        if (!(&valid)) begin
            for (int i = N_WAYS - 1; i >= 0; i--)
                if (!valid[i]) v = NWAY_W'(i);
        end else begin
            case (pol)
                POL_LRU:
                    for (int i = N_WAYS - 1; i >= 0; i--)
                        if (st[i*NWAY_W +: NWAY_W] == '0) v = NWAY_W'(i);
                POL_MRU:
                    for (int i = N_WAYS - 1; i >= 0; i--)
                        if (!st[i]) v = NWAY_W'(i);
                POL_TREE:
                    for (int lvl = 0; lvl < NWAY_W; lvl++) begin
                        b                = st[n];
                        v[NWAY_W-1-lvl]  = b;
                        n                = 2 * n + (b ? 2 : 1);
                    end
                default: v = rnd[NWAY_W-1:0];
            endcase
        end
        return v;
    endfunction

    assign look_ready = ~busy;
    assign look_fire  = look_valid & ~busy;
    assign flush_take = flush_req & (state == ST_IDLE);
    assign upd_fire   = upd_en & ~busy & (|upd_way_hit) & ~flush_take;
    assign upd_next   = update_state(mem[upd_addr], upd_way_hit, policy);

    // Same-set update in the lookup cycle is forwarded so the victim reflects the access.
    always_comb begin
        look_state = mem[look_addr];
        if (upd_fire && (upd_addr == look_addr)) look_state = upd_next;
    end

    assign victim = pick_victim(look_state, way_valid, policy, lfsr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_SWEEP;
            cnt            <= '0;
            busy           <= 1'b1;
            policy         <= policy_sel;
            lfsr           <= LFSR_SEED;
            sel_valid      <= 1'b0;
            way_select     <= '0;
            way_select_bin <= '0;
        end else begin
            sel_valid <= look_fire;
            if (look_fire) begin
                way_select     <= N_WAYS'(1) << victim;
                way_select_bin <= victim;
                if (policy == POL_RAND)
                    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
            case (state)
                ST_SWEEP: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (flush_req) begin
                        policy <= policy_sel;
                        state  <= ST_SWEEP;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_SWEEP)  mem[cnt]      <= init_state(policy);
        else if (upd_fire)      mem[upd_addr] <= upd_next;
    end

endmodule

// File: tb/tb_replacement_policy_ctrl.sv
// tb/tb_replacement_policy_ctrl.sv - directed self-checking bench for replacement_policy_ctrl
module tb_replacement_policy_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] policy_sel;
    logic       flush_req;
    logic       busy;
    logic       look_valid;
    logic       look_ready;
    logic [1:0] look_addr;
    logic [3:0] way_valid;
    logic       sel_valid;
    logic [3:0] way_select;
    logic [1:0] way_select_bin;
    logic       upd_en;
    logic [1:0] upd_addr;
    logic [3:0] upd_way_hit;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    replacement_policy_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .policy_sel     (policy_sel),
        .flush_req      (flush_req),
        .busy           (busy),
        .look_valid     (look_valid),
        .look_ready     (look_ready),
        .look_addr      (look_addr),
        .way_valid      (way_valid),
        .sel_valid      (sel_valid),
        .way_select     (way_select),
        .way_select_bin (way_select_bin),
        .upd_en         (upd_en),
        .upd_addr       (upd_addr),
        .upd_way_hit    (upd_way_hit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sweep(input string tag);
        int n;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk(tag, n, 4);
    endtask

    task automatic look(input string tag, input logic [1:0] addr, input logic [3:0] wv,
                        input logic [3:0] exp_oh, input logic [1:0] exp_bin);
        look_valid = 1'b1;
        look_addr  = addr;
        way_valid  = wv;
        step();
        look_valid = 1'b0;
        chk({tag, "_sv"}, sel_valid, 1);
        chk({tag, "_oh"}, way_select, exp_oh);
        chk({tag, "_bin"}, way_select_bin, exp_bin);
    endtask

    task automatic upd(input logic [1:0] addr, input logic [3:0] hit);
        upd_en      = 1'b1;
        upd_addr    = addr;
        upd_way_hit = hit;
        step();
        upd_en      = 1'b0;
    endtask

    task automatic flush(input string tag, input logic [1:0] pol);
        policy_sel = pol;
        flush_req  = 1'b1;
        step();
        flush_req  = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        wait_sweep({tag, "_len"});
    endtask

    initial begin
        reset_n     = 1'b0;
        policy_sel  = 2'd0;
        flush_req   = 1'b0;
        look_valid  = 1'b0;
        look_addr   = '0;
        way_valid   = 4'hF;
        upd_en      = 1'b0;
        upd_addr    = '0;
        upd_way_hit = '0;
        repeat (3) step();
        chk("rst_busy", busy, 1);
        chk("rst_ready", look_ready, 0);
        chk("rst_sel_valid", sel_valid, 0);
        chk("rst_way", way_select, 0);
        chk("rst_bin", way_select_bin, 0);
        reset_n = 1'b1;
        wait_sweep("rst_sweep_len");
        chk("idle_ready", look_ready, 1);

        look("lru_init", 2'd0, 4'hF, 4'b0001, 2'd0);
        step();
        chk("idle_sel_valid", sel_valid, 0);
        chk("idle_hold", way_select, 4'b0001);

        upd(2'd1, 4'b0001);
        upd(2'd1, 4'b0010);
        upd(2'd1, 4'b0100);
        look("lru_w3", 2'd1, 4'hF, 4'b1000, 2'd3);
        upd(2'd1, 4'b1000);
        look("lru_w0", 2'd1, 4'hF, 4'b0001, 2'd0);
        look("lru_inv", 2'd1, 4'b1011, 4'b0100, 2'd2);

        flush("fl_tree", 2'd3);
        upd(2'd0, 4'b0001);
        look("tree_w2", 2'd0, 4'hF, 4'b0100, 2'd2);
        upd(2'd0, 4'b0100);
        look("tree_w1", 2'd0, 4'hF, 4'b0010, 2'd1);
        look("tree_inv", 2'd0, 4'b1011, 4'b0100, 2'd2);

        flush("fl_mru", 2'd1);
        upd(2'd3, 4'b0001);
        upd(2'd3, 4'b0010);
        look("mru_w2", 2'd3, 4'hF, 4'b0100, 2'd2);
        upd(2'd3, 4'b0100);
        upd(2'd3, 4'b1000);
        look("mru_wrap", 2'd3, 4'hF, 4'b0001, 2'd0);

        flush("fl_lru", 2'd0);
        upd_en      = 1'b1;
        upd_addr    = 2'd2;
        upd_way_hit = 4'b0001;
        look("bypass", 2'd2, 4'hF, 4'b0010, 2'd1);
        upd_en      = 1'b0;
        look("nobypass", 2'd3, 4'hF, 4'b0001, 2'd0);

        begin
            int n;
            policy_sel  = 2'd2;
            flush_req   = 1'b1;
            upd_en      = 1'b1;
            upd_addr    = 2'd0;
            upd_way_hit = 4'b0001;
            step();
            flush_req   = 1'b0;
            look_valid  = 1'b1;
            way_valid   = 4'hF;
            n = 0;
            while (busy && n < 20) begin
                chk("busy_ready", look_ready, 0);
                step();
                chk("busy_sel_valid", sel_valid, 0);
                n++;
            end
            chk("rand_sweep_len", n, 4);
            look_valid = 1'b0;
            upd_en     = 1'b0;
        end
        look("rand0", 2'd0, 4'hF, 4'b0010, 2'd1);
        look("rand1", 2'd1, 4'hF, 4'b1000, 2'd3);
        look("rand2", 2'd2, 4'hF, 4'b1000, 2'd3);
        look("rand3", 2'd3, 4'hF, 4'b1000, 2'd3);
        look("rand_inv", 2'd0, 4'b1110, 4'b0001, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
